// File: rtl/present_pkg.sv
// present_pkg: shared definitions for the iterative PRESENT cipher core.
//   - RC_W         width of the 5-bit round counter
//   - fsm_e        controller states IDLE / KEYFWD / RUN / DONE
//   - sbox         PRESENT 4-bit S-box; s_layer applies it to all 16 nibbles
//   - perm_idx     destination bit of the PRESENT bit permutation
//   - p_layer      64-bit bit permutation
//   - sbox_inv, s_inv_layer, p_inv_layer: inverse layers, present only when
//     PRESENT_DEC_EN is defined
package present_pkg;

  localparam int RC_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_KEYFWD = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } fsm_e;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Bit i of the input lands on bit (16*i) mod 63; bit 63 stays in place.
  function automatic logic [5:0] perm_idx(input logic [5:0] i);
    logic [9:0] prod;
    prod = {i, 4'b0000};
    return (i == 6'd63) ? 6'd63 : 6'(prod % 10'd63);
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) y[6'(4*n) +: 4] = sbox(x[6'(4*n) +: 4]);
    return y;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[perm_idx(6'(i))] = x[6'(i)];
    return y;
  endfunction

`ifdef PRESENT_DEC_EN
  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] s_inv_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) y[6'(4*n) +: 4] = sbox_inv(x[6'(4*n) +: 4]);
    return y;
  endfunction

  function automatic logic [63:0] p_inv_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(i)] = x[perm_idx(6'(i))];
    return y;
  endfunction
`endif

endpackage

// File: rtl/present_key_sched.sv
// present_key_sched: combinational PRESENT key-schedule step.
//   key_in  [KEY_W]  current key register
//   rc      [RC_W]   round counter of the step being applied
//   key_fwd [KEY_W]  ks(key_in, rc): rotate left 61, S on the top nibble(s),
//                    round counter folded into the key
//   key_inv [KEY_W]  ks_inv(key_in, rc), the exact inverse step; port exists
//                    only when PRESENT_DEC_EN is defined
module present_key_sched
  import present_pkg::*;
#(
  parameter int KEY_W = 80
) (
  input  logic [KEY_W-1:0] key_in,
  input  logic [RC_W-1:0]  rc,
  output logic [KEY_W-1:0] key_fwd
`ifdef PRESENT_DEC_EN
  ,
  output logic [KEY_W-1:0] key_inv
`endif
);

  // NOTE: combinational blocks use blocking '=' and assign every output
  // first, so each bit always has a value and no latch is inferred.
  always_comb begin
    key_fwd = {key_in[KEY_W-62:0], key_in[KEY_W-1:KEY_W-61]};
    key_fwd[KEY_W-1 -: 4] = sbox(key_fwd[KEY_W-1 -: 4]);
    if (KEY_W == 128) begin
      key_fwd[KEY_W-5 -: 4] = sbox(key_fwd[KEY_W-5 -: 4]);
      key_fwd[66:62]        = key_fwd[66:62] ^ rc;
    end else begin
      key_fwd[19:15] = key_fwd[19:15] ^ rc;
    end
  end

`ifdef PRESENT_DEC_EN
  logic [KEY_W-1:0] unrot;

  // The S-box and counter touch disjoint bits, so undoing them in either
  // order is fine; the rotation must be undone last.
  always_comb begin
    unrot = key_in;
    unrot[KEY_W-1 -: 4] = sbox_inv(unrot[KEY_W-1 -: 4]);
    if (KEY_W == 128) begin
      unrot[KEY_W-5 -: 4] = sbox_inv(unrot[KEY_W-5 -: 4]);
      unrot[66:62]        = unrot[66:62] ^ rc;
    end else begin
      unrot[19:15] = unrot[19:15] ^ rc;
    end
    key_inv = {unrot[60:0], unrot[KEY_W-1:61]};
  end
`endif

endmodule

// File: rtl/present_core.sv
// present_core: iterative PRESENT block cipher, one round per clock, with
// the key schedule computed on the fly. Holds one block in flight.
// Parameters: KEY_W (80 or 128), ROUNDS (31 for the full cipher).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake; in_ready is high only in IDLE
//   in_text [64]          plaintext (ciphertext when decrypting)
//   in_key  [KEY_W]       cipher key
//   in_dec                1 = decrypt (only with PRESENT_DEC_EN)
//   out_valid / out_ready result handshake; out_valid held until accepted
//   out_text [64]         result, stable while out_valid && !out_ready
// Macro PRESENT_DEC_EN adds in_dec, the KEYFWD state and the inverse datapath;
// without it the core is encrypt-only.
module present_core
  import present_pkg::*;
#(
  parameter int KEY_W  = 80,
  parameter int ROUNDS = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_text,
  input  logic [KEY_W-1:0] in_key,
`ifdef PRESENT_DEC_EN
  input  logic             in_dec,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_text
);

  if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
    $error("present_core: KEY_W must be 80 or 128");
  end
  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("present_core: ROUNDS must be in 1..31");
  end

  localparam logic [RC_W-1:0] FIRST_RC = RC_W'(1);
  localparam logic [RC_W-1:0] LAST_RC  = RC_W'(ROUNDS);

  fsm_e             fsm_q, fsm_d;
  logic [63:0]      state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic             out_valid_q, out_valid_d;
  logic [63:0]      out_text_q, out_text_d;
  logic [KEY_W-1:0] ks_fwd;
  logic [63:0]      enc_out;
`ifdef PRESENT_DEC_EN
  logic             dec_q, dec_d;
  logic [KEY_W-1:0] ks_inv;
  logic [63:0]      dec_out;
`endif

  present_key_sched #(.KEY_W(KEY_W)) u_key_sched (
    .key_in  (key_q),
    .rc      (rc_q),
    .key_fwd (ks_fwd)
`ifdef PRESENT_DEC_EN
    ,
    .key_inv (ks_inv)
`endif
  );

  assign enc_out = p_layer(s_layer(state_q ^ key_q[KEY_W-1 -: 64]));
`ifdef PRESENT_DEC_EN
  // Decrypt round: the round key is the one just recovered by ks_inv.
  assign dec_out = s_inv_layer(p_inv_layer(state_q)) ^ ks_inv[KEY_W-1 -: 64];
`endif

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    key_d       = key_q;
    rc_d        = rc_q;
    out_valid_d = out_valid_q;
    out_text_d  = out_text_q;
`ifdef PRESENT_DEC_EN
    dec_d       = dec_q;
`endif
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = in_text;
          key_d   = in_key;
          rc_d    = FIRST_RC;
`ifdef PRESENT_DEC_EN
          dec_d   = in_dec;
          fsm_d   = in_dec ? ST_KEYFWD : ST_RUN;
`else
          fsm_d   = ST_RUN;
`endif
        end
      end
`ifdef PRESENT_DEC_EN
      // Walk the schedule forward to the final whitening key, then strip it.
      ST_KEYFWD: begin
        key_d = ks_fwd;
        rc_d  = rc_q + FIRST_RC;
        if (rc_q == LAST_RC) begin
          state_d = state_q ^ ks_fwd[KEY_W-1 -: 64];
          rc_d    = LAST_RC;
          fsm_d   = ST_RUN;
        end
      end
`endif
      ST_RUN: begin
`ifdef PRESENT_DEC_EN
        if (dec_q) begin
          state_d = dec_out;
          key_d   = ks_inv;
          rc_d    = rc_q - FIRST_RC;
          if (rc_q == FIRST_RC) begin
            out_text_d  = dec_out;
            out_valid_d = 1'b1;
            fsm_d       = ST_DONE;
          end
        end else
`endif
        begin
          state_d = enc_out;
          key_d   = ks_fwd;
          rc_d    = rc_q + FIRST_RC;
          // Last round: apply the final whitening key on the way out.
          if (rc_q == LAST_RC) begin
            out_text_d  = enc_out ^ ks_fwd[KEY_W-1 -: 64];
            out_valid_d = 1'b1;
            fsm_d       = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = ST_IDLE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking '<=' so every flop samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= ST_IDLE;
      state_q     <= '0;
      key_q       <= '0;
      rc_q        <= '0;
      out_valid_q <= 1'b0;
      out_text_q  <= '0;
`ifdef PRESENT_DEC_EN
      dec_q       <= 1'b0;
`endif
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      key_q       <= key_d;
      rc_q        <= rc_d;
      out_valid_q <= out_valid_d;
      out_text_q  <= out_text_d;
`ifdef PRESENT_DEC_EN
      dec_q       <= dec_d;
`endif
    end
  end

  assign in_ready  = (fsm_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_text  = out_text_q;

endmodule

// File: tb/tb_present_core.sv
// tb_present_core: self-checking bench for present_core. Two instances
// (KEY_W=80 and KEY_W=128) share clock and reset; results are compared with
// known-answer vectors and with a behavioural PRESENT model that derives the
// round-key list up front and runs the rounds with plain loops.
// With PRESENT_DEC_EN defined the decrypt path and round trips are exercised.
module tb_present_core;

  localparam int ROUNDS = 31;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   in_valid;
  logic [1:0]   out_ready;
  logic [63:0]  in_text;
  logic [127:0] in_key;
`ifdef PRESENT_DEC_EN
  logic         in_dec;
`endif
  logic [1:0]   in_ready_w;
  logic [1:0]   out_valid_w;
  logic [63:0]  out_text_80;
  logic [63:0]  out_text_128;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] m_sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                            4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  always #5 clk = ~clk;

  present_core #(.KEY_W(80), .ROUNDS(ROUNDS)) u_dut80 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready_w[0]),
    .in_text   (in_text),
    .in_key    (in_key[79:0]),
`ifdef PRESENT_DEC_EN
    .in_dec    (in_dec),
`endif
    .out_valid (out_valid_w[0]),
    .out_ready (out_ready[0]),
    .out_text  (out_text_80)
  );

  present_core #(.KEY_W(128), .ROUNDS(ROUNDS)) u_dut128 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready_w[1]),
    .in_text   (in_text),
    .in_key    (in_key),
`ifdef PRESENT_DEC_EN
    .in_dec    (in_dec),
`endif
    .out_valid (out_valid_w[1]),
    .out_ready (out_ready[1]),
    .out_text  (out_text_128)
  );

  // ---------------- reference model ----------------
  function automatic int m_pos(input int b);
    return (b == 63) ? 63 : (b * 16) % 63;
  endfunction

  function automatic logic [3:0] m_sb_inv(input logic [3:0] x);
    logic [3:0] r;
    r = 4'h0;
    for (int j = 0; j < 16; j++) if (m_sb[j] == x) r = 4'(j);
    return r;
  endfunction

  function automatic logic [127:0] m_ks(input logic [127:0] k, input int kw, input int rc);
    logic [127:0] mask, r;
    mask = (kw == 128) ? {128{1'b1}} : {48'd0, {80{1'b1}}};
    k = k & mask;
    r = ((k << 61) | (k >> (kw - 61))) & mask;
    r[7'(kw-1) -: 4] = m_sb[r[7'(kw-1) -: 4]];
    if (kw == 128) r[7'(kw-5) -: 4] = m_sb[r[7'(kw-5) -: 4]];
    r = r ^ (128'(rc & 31) << ((kw == 80) ? 15 : 62));
    return r;
  endfunction

  function automatic logic [63:0] m_cipher(input logic [63:0] txt, input logic [127:0] key,
                                           input int kw, input bit dec);
    logic [63:0]  rk [33];
    logic [127:0] k;
    logic [63:0]  s, t;
    k = (kw == 128) ? key : {48'd0, key[79:0]};
    for (int r = 1; r <= ROUNDS + 1; r++) begin
      rk[6'(r)] = 64'(k >> (kw - 64));
      k = m_ks(k, kw, r);
    end
    s = txt;
    if (!dec) begin
      for (int r = 1; r <= ROUNDS; r++) begin
        s = s ^ rk[6'(r)];
        for (int n = 0; n < 16; n++) s[6'(4*n) +: 4] = m_sb[s[6'(4*n) +: 4]];
        t = '0;
        for (int b = 0; b < 64; b++) t[6'(m_pos(b))] = s[6'(b)];
        s = t;
      end
      s = s ^ rk[6'(ROUNDS + 1)];
    end else begin
      s = s ^ rk[6'(ROUNDS + 1)];
      for (int r = ROUNDS; r >= 1; r--) begin
        t = '0;
        for (int b = 0; b < 64; b++) t[6'(b)] = s[6'(m_pos(b))];
        for (int n = 0; n < 16; n++) t[6'(4*n) +: 4] = m_sb_inv(t[6'(4*n) +: 4]);
        s = t ^ rk[6'(r)];
      end
    end
    return s;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] get_ot(input bit sel);
    return sel ? out_text_128 : out_text_80;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic start(input bit sel, input logic [63:0] txt, input logic [127:0] key,
                       input string tag);
    check({tag, " ready"}, 64'(in_ready_w[sel]), 64'd1);
    in_valid[sel] = 1'b1;
    in_text       = txt;
    in_key        = key;
    @(posedge clk);
    @(negedge clk);
    in_valid[sel] = 1'b0;
  endtask

  task automatic wait_out(input bit sel, input int lat, input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (out_valid_w[sel] !== 1'b1 && n < 200);
    check({tag, " latency"}, 64'(n), 64'(lat));
  endtask

  task automatic drain(input bit sel);
    out_ready[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[sel] = 1'b0;
  endtask

  task automatic run_block(input bit sel, input logic [63:0] txt, input logic [127:0] key,
                           input bit dec, input string tag, output logic [63:0] res);
    logic [63:0] exp;
    exp = m_cipher(txt, key, sel ? 128 : 80, dec);
`ifdef PRESENT_DEC_EN
    in_dec = dec;
`endif
    start(sel, txt, key, tag);
    wait_out(sel, dec ? 2 * ROUNDS : ROUNDS, tag);
    res = get_ot(sel);
    check({tag, " text"}, res, exp);
    drain(sel);
    check({tag, " idle"}, 64'(in_ready_w[sel]), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  res, exp_a, exp_b, pt, ct;
    logic [127:0] key;

    in_valid  = '0;
    out_ready = '0;
    in_text   = '0;
    in_key    = '0;
`ifdef PRESENT_DEC_EN
    in_dec    = 1'b0;
`endif
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst in_ready80",  64'(in_ready_w[0]),  64'd1);
    check("rst in_ready128", 64'(in_ready_w[1]),  64'd1);
    check("rst out_valid80", 64'(out_valid_w[0]), 64'd0);
    check("rst out_valid128",64'(out_valid_w[1]), 64'd0);
    check("rst out_text80",  out_text_80,  64'd0);
    check("rst out_text128", out_text_128, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Known-answer vectors.
    run_block(1'b0, 64'd0, 128'd0, 1'b0, "kat80_zero", res);
    check("kat80_zero const", res, 64'h5579C1387B228445);
    run_block(1'b0, {64{1'b1}}, {128{1'b1}}, 1'b0, "kat80_ones", res);
    check("kat80_ones const", res, 64'h3333DCD3213210D2);
    run_block(1'b0, 64'd0, {128{1'b1}}, 1'b0, "kat80_k1", res);
    check("kat80_k1 const", res, 64'hE72C46C0F5945049);
    run_block(1'b1, 64'd0, 128'd0, 1'b0, "kat128_zero", res);
    check("kat128_zero const", res, 64'h96DB702A2E6900AF);

    // out_ready while idle must not disturb anything.
    out_ready[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("idle ready ignored in_ready", 64'(in_ready_w[0]), 64'd1);
    check("idle ready ignored out_valid", 64'(out_valid_w[0]), 64'd0);
    out_ready[0] = 1'b0;

    // Backpressure: result and in_ready frozen while out_ready is low.
    key   = {$urandom, $urandom, $urandom, $urandom};
    pt    = {$urandom, $urandom};
    exp_a = m_cipher(pt, key, 80, 1'b0);
    start(1'b0, pt, key, "bp");
    wait_out(1'b0, ROUNDS, "bp");
    for (int c = 0; c < 10; c++) begin
      check("bp hold text", out_text_80, exp_a);
      check("bp hold valid", 64'(out_valid_w[0]), 64'd1);
      check("bp hold in_ready", 64'(in_ready_w[0]), 64'd0);
      @(negedge clk);
    end
    drain(1'b0);
    check("bp release in_ready", 64'(in_ready_w[0]), 64'd1);
    check("bp release valid", 64'(out_valid_w[0]), 64'd0);

    // Back-to-back with in_valid held high across the busy period.
    key   = {$urandom, $urandom, $urandom, $urandom};
    pt    = {$urandom, $urandom};
    exp_a = m_cipher(pt, key, 80, 1'b0);
    in_valid[0] = 1'b1;
    in_text     = pt;
    in_key      = key;
    @(posedge clk);
    @(negedge clk);
    key   = {$urandom, $urandom, $urandom, $urandom};
    pt    = {$urandom, $urandom};
    exp_b = m_cipher(pt, key, 80, 1'b0);
    in_text = pt;
    in_key  = key;
    check("b2b busy", 64'(in_ready_w[0]), 64'd0);
    wait_out(1'b0, ROUNDS, "b2b first");
    check("b2b first text", out_text_80, exp_a);
    out_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("b2b idle between", 64'(in_ready_w[0]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    check("b2b second taken", 64'(in_ready_w[0]), 64'd0);
    wait_out(1'b0, ROUNDS, "b2b second");
    check("b2b second text", out_text_80, exp_b);
    drain(1'b0);

    // Reset in the middle of a block (rc==15).
    start(1'b0, 64'h0123456789ABCDEF, 128'h5A5A, "mid_rst");
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst out_valid", 64'(out_valid_w[0]), 64'd0);
    check("mid_rst in_ready", 64'(in_ready_w[0]), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_block(1'b0, 64'h0123456789ABCDEF, 128'h5A5A, 1'b0, "post_rst", res);

`ifdef PRESENT_DEC_EN
    run_block(1'b0, 64'h5579C1387B228445, 128'd0, 1'b1, "kat80_dec", res);
    check("kat80_dec const", res, 64'd0);
    for (int v = 0; v < 300; v++) begin
      bit sel;
      sel = v[0];
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom};
      run_block(sel, pt, key, 1'b0, "rt enc", ct);
      run_block(sel, ct, key, 1'b1, "rt dec", res);
      check("rt plain", res, pt);
    end
`else
    for (int v = 0; v < 50; v++) begin
      bit sel;
      sel = v[0];
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom};
      run_block(sel, pt, key, 1'b0, "rand enc", res);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
